pipe_ctrl: RTL and testbench

Central pipeline sequencer for the PC, IF, ID/IDROB, EX and MEM stages. It merges per-stage stall requests into per-stage stall enables, drives `stall_current_stage`/`stall_next_stage` of IDROB and the other stage registers, and sequences flushes and PC redirects for exceptions (full flush) and branch mispredicts (front-end flush). It also counts stall cycles for performance debug.

---
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests in, stall/flush/redirect controls out.
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  stall_req_if;
  logic                  stall_req_id;
  logic                  stall_req_ex;
  logic                  stall_req_mem;
  logic                  exc_valid;
  logic [ADDR_WIDTH-1:0] exc_handler_pc;
  logic                  mispredict;
  logic [ADDR_WIDTH-1:0] mispredict_pc;
  logic                  cnt_clear;
  logic                  stall_pc;
  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  stall_mem;
  logic                  flush;
  logic                  flush_front;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  stall_cycles;

  // Controller side
  modport master (
    input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
    input  exc_valid, exc_handler_pc, mispredict, mispredict_pc, cnt_clear,
    output stall_pc, stall_if, stall_id, stall_ex, stall_mem,
    output flush, flush_front, redirect_valid, redirect_pc, busy, stall_cycles
  );

  // Pipeline side
  modport slave (
    output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
    output exc_valid, exc_handler_pc, mispredict, mispredict_pc, cnt_clear,
    input  stall_pc, stall_if, stall_id, stall_ex, stall_mem,
    input  flush, flush_front, redirect_valid, redirect_pc, busy, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: stall merge, exception/mispredict flush and PC redirect,
// plus a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  pif
);

  localparam int unsigned FC_W = 4;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    FLUSH         = 2'd1,
    REDIRECT      = 2'd2,
    HOLD_REDIRECT = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [FC_W-1:0]       flush_cnt, flush_cnt_nxt;
  logic [ADDR_WIDTH-1:0] redirect_pc, redirect_pc_nxt;
  logic [CNT_WIDTH-1:0]  stall_cycles;
  logic                  flush, flush_front, redirect_valid;
  logic                  idle;
  logic                  stall_mem, stall_ex, stall_id, stall_if, stall_pc;

  // Stalls only apply while idle; reset also masks them so outputs drop at once
  assign idle      = (state == IDLE) && !rst;
  assign stall_mem = idle && pif.stall_req_mem;
  assign stall_ex  = stall_mem || (idle && pif.stall_req_ex);
  assign stall_id  = stall_ex  || (idle && pif.stall_req_id);
  assign stall_if  = stall_id  || (idle && pif.stall_req_if);
  assign stall_pc  = stall_if;

  // State, flush countdown and redirect target registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= state_nxt;
      flush_cnt   <= flush_cnt_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

  // Next-state and control decode; an exception always wins over anything else
  always_comb begin
    state_nxt       = state;
    flush_cnt_nxt   = flush_cnt;
    redirect_pc_nxt = redirect_pc;
    flush           = 1'b0;
    flush_front     = 1'b0;
    redirect_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (pif.exc_valid) begin
          state_nxt       = FLUSH;
          redirect_pc_nxt = pif.exc_handler_pc;
          flush_cnt_nxt   = FC_W'(FLUSH_CYCLES - 1);
        end else if (pif.mispredict) begin
          flush_front     = 1'b1;
          redirect_pc_nxt = pif.mispredict_pc;
          state_nxt       = REDIRECT;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (pif.exc_valid) begin
          redirect_pc_nxt = pif.exc_handler_pc;
          flush_cnt_nxt   = FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt != '0) begin
          flush_cnt_nxt = flush_cnt - FC_W'(1);
        end else begin
          state_nxt = REDIRECT;
        end
      end
      REDIRECT, HOLD_REDIRECT: begin
        // A late exception must not be lost behind a pending redirect
        if (pif.exc_valid) begin
          state_nxt       = FLUSH;
          redirect_pc_nxt = pif.exc_handler_pc;
          flush_cnt_nxt   = FC_W'(FLUSH_CYCLES - 1);
        end else if (!pif.stall_req_if) begin
          redirect_valid = 1'b1;
          state_nxt      = IDLE;
        end else begin
          state_nxt = HOLD_REDIRECT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating stall-cycle counter; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (pif.cnt_clear) begin
      stall_cycles <= '0;
    end else if (stall_pc && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

  assign pif.stall_pc       = stall_pc;
  assign pif.stall_if       = stall_if;
  assign pif.stall_id       = stall_id;
  assign pif.stall_ex       = stall_ex;
  assign pif.stall_mem      = stall_mem;
  assign pif.flush          = flush;
  assign pif.flush_front    = flush_front && !rst;
  assign pif.redirect_valid = redirect_valid;
  assign pif.redirect_pc    = redirect_pc;
  assign pif.busy           = (state != IDLE);
  assign pif.stall_cycles   = stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues per-cycle expected outputs,
// the monitor pops and compares them on the falling edge.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) pif ();

  pipe_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  typedef struct packed {
    logic [4:0]  stl;   // {pc, if, id, ex, mem}
    logic        fl;
    logic        ff;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mon_cyc = 0;

  localparam logic [31:0] PC_EXC = 32'hbfc00380;
  localparam logic [31:0] PC_BR  = 32'hbfc00024;
  localparam logic [31:0] PC_BR2 = 32'hbfc00010;

  task automatic chk(input string nm, input int cyc_n, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, req);
  endtask

  // One stimulus cycle: drive inputs just after the rising edge, queue the expected outputs
  task automatic cyc(input logic r, input logic [3:0] req, input logic exc, input logic [31:0] epc,
                     input logic mis, input logic [31:0] mpc, input logic clr,
                     input logic [4:0] e_stl, input logic e_fl, input logic e_ff, input logic e_rv,
                     input logic [31:0] e_rpc, input logic e_busy, input logic [3:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    pif.stall_req_if   = req[3];
    pif.stall_req_id   = req[2];
    pif.stall_req_ex   = req[1];
    pif.stall_req_mem  = req[0];
    pif.exc_valid      = exc;
    pif.exc_handler_pc = epc;
    pif.mispredict     = mis;
    pif.mispredict_pc  = mpc;
    pif.cnt_clear      = clr;
    e.stl  = e_stl;
    e.fl   = e_fl;
    e.ff   = e_ff;
    e.rv   = e_rv;
    e.rpc  = e_rpc;
    e.busy = e_busy;
    e.cnt  = e_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stalls", mon_cyc, 32'({pif.stall_pc, pif.stall_if, pif.stall_id, pif.stall_ex, pif.stall_mem}), 32'(e.stl));
      chk("flush", mon_cyc, 32'(pif.flush), 32'(e.fl));
      chk("flush_front", mon_cyc, 32'(pif.flush_front), 32'(e.ff));
      chk("redirect_valid", mon_cyc, 32'(pif.redirect_valid), 32'(e.rv));
      chk("redirect_pc", mon_cyc, pif.redirect_pc, e.rpc);
      chk("busy", mon_cyc, 32'(pif.busy), 32'(e.busy));
      chk("stall_cycles", mon_cyc, 32'(pif.stall_cycles), 32'(e.cnt));
      mon_cyc++;
    end
  end

  initial begin
    int wait_n;
    rst                = 1'b1;
    pif.stall_req_if   = 1'b0;
    pif.stall_req_id   = 1'b0;
    pif.stall_req_ex   = 1'b0;
    pif.stall_req_mem  = 1'b0;
    pif.exc_valid      = 1'b0;
    pif.exc_handler_pc = '0;
    pif.mispredict     = 1'b0;
    pif.mispredict_pc  = '0;
    pif.cnt_clear      = 1'b0;

    //  r  req      exc epc        mis mpc      clr  stl      fl ff rv rpc           busy cnt
    // reset state
    cyc(1, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    // stall merge: EX request stalls pc/if/id/ex, counter runs, release is immediate
    cyc(0, 4'b0010, 0, 32'h0,     0, 32'h0,   0,   5'b11110, 0, 0, 0, 32'h0,        0, 4'd0);
    cyc(0, 4'b0010, 0, 32'h0,     0, 32'h0,   0,   5'b11110, 0, 0, 0, 32'h0,        0, 4'd1);
    cyc(0, 4'b0010, 0, 32'h0,     0, 32'h0,   0,   5'b11110, 0, 0, 0, 32'h0,        0, 4'd2);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd3);
    cyc(0, 4'b0001, 0, 32'h0,     0, 32'h0,   0,   5'b11111, 0, 0, 0, 32'h0,        0, 4'd3);
    cyc(0, 4'b1000, 0, 32'h0,     0, 32'h0,   0,   5'b11000, 0, 0, 0, 32'h0,        0, 4'd4);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   1,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd5);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    // exception: two flush cycles (stall and mispredict ignored), redirect, idle
    cyc(0, 4'b0000, 1, PC_EXC,    0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    cyc(0, 4'b0010, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 1, 0, 0, PC_EXC,       1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     1, PC_BR2,  0,   5'b00000, 1, 0, 0, PC_EXC,       1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 1, PC_EXC,       1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_EXC,       0, 4'd0);
    // mispredict: front flush same cycle, redirect next cycle
    cyc(0, 4'b0000, 0, 32'h0,     1, PC_BR,   0,   5'b00000, 0, 1, 0, PC_EXC,       0, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 1, PC_BR,        1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_BR,        0, 4'd0);
    // simultaneous exception and mispredict: exception only
    cyc(0, 4'b0000, 1, PC_EXC,    1, PC_BR2,  0,   5'b00000, 0, 0, 0, PC_BR,        0, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 1, 0, 0, PC_EXC,       1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 1, 0, 0, PC_EXC,       1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 1, PC_EXC,       1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_EXC,       0, 4'd0);
    // mispredict with IF stall: redirect held until the stall drops
    cyc(0, 4'b0000, 0, 32'h0,     1, PC_BR,   0,   5'b00000, 0, 1, 0, PC_EXC,       0, 4'd0);
    cyc(0, 4'b1000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_BR,        1, 4'd0);
    cyc(0, 4'b1000, 0, 32'h0,     1, 32'h1234,0,   5'b00000, 0, 0, 0, PC_BR,        1, 4'd0);
    cyc(0, 4'b1000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_BR,        1, 4'd0);
    cyc(0, 4'b1000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_BR,        1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 1, PC_BR,        1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_BR,        0, 4'd0);
    // counter saturation at 4'hf, then clear wins over increment
    for (int i = 0; i < 17; i++)
      cyc(0, 4'b0001, 0, 32'h0,   0, 32'h0,   0,   5'b11111, 0, 0, 0, PC_BR,        0, (i > 15) ? 4'd15 : 4'(i));
    cyc(0, 4'b0001, 0, 32'h0,     0, 32'h0,   1,   5'b11111, 0, 0, 0, PC_BR,        0, 4'd15);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, PC_BR,        0, 4'd0);
    // reset mid-flush clears outputs at once, no redirect afterwards
    cyc(0, 4'b0000, 1, 32'h80000180, 0, 32'h0, 0,  5'b00000, 0, 0, 0, PC_BR,        0, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 1, 0, 0, 32'h80000180, 1, 4'd0);
    cyc(1, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    // exception during flush restarts the countdown with the new target
    cyc(0, 4'b0000, 1, 32'h1000,  0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h0,        0, 4'd0);
    cyc(0, 4'b0000, 1, 32'h2000,  0, 32'h0,   0,   5'b00000, 1, 0, 0, 32'h1000,     1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 1, 0, 0, 32'h2000,     1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 1, 0, 0, 32'h2000,     1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 1, 32'h2000,     1, 4'd0);
    cyc(0, 4'b0000, 0, 32'h0,     0, 32'h0,   0,   5'b00000, 0, 0, 0, 32'h2000,     0, 4'd0);

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
